// File: rtl/ara_eoc_ctrl_regs.sv
// End-of-computation and trace-control register block.
// Terminates AXI4-Lite-style scalar-core accesses to EXIT, EVENT_TRIGGER,
// HW_CNT_EN and the read-only CYCLE_COUNT measured-region counter.
module ara_eoc_ctrl_regs #(
    parameter int unsigned          AddrWidth = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(64'hD000_0000)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [63:0]          w_data_i,
    input  logic [7:0]           w_strb_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    output logic [1:0]           b_resp_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    output logic [63:0]          r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [63:0]          exit_o,
    output logic [63:0]          event_trigger_o,
    output logic [63:0]          hw_cnt_en_o,
    output logic [63:0]          cycle_count_o
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    localparam logic [1:0] StWIdle   = 2'd0;
    localparam logic [1:0] StWHaveAw = 2'd1;
    localparam logic [1:0] StWHaveW  = 2'd2;
    localparam logic [1:0] StWResp   = 2'd3;

    localparam logic StRIdle = 1'b0;
    localparam logic StRResp = 1'b1;

    localparam logic [1:0] IdxExit  = 2'd0;
    localparam logic [1:0] IdxEvent = 2'd1;
    localparam logic [1:0] IdxCntEn = 2'd2;
    localparam logic [1:0] IdxCount = 2'd3;

    // Returns {mapped, register index}; addresses below BaseAddr wrap to a
    // large offset and so fall out of the map naturally.
    function automatic logic [2:0] decode(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] off;
        logic                 mapped;
        off    = addr - BaseAddr;
        mapped = (off[AddrWidth-1:5] == '0) && (addr[2:0] == 3'b000);
        return {mapped, off[4:3]};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_val,
                                          input logic [63:0] new_val,
                                          input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    logic [1:0]           wr_state_q, wr_state_d;
    logic [AddrWidth-1:0] wr_addr_q;
    logic [63:0]          wr_data_q;
    logic [7:0]           wr_strb_q;
    logic [1:0]           b_resp_q;

    logic                 rd_state_q, rd_state_d;
    logic [63:0]          r_data_q;
    logic [1:0]           r_resp_q;

    logic [63:0] exit_q, exit_d;
    logic [63:0] event_q, event_d;
    logic [63:0] cnt_en_q, cnt_en_d;
    logic [63:0] count_q, count_d;

    logic                 aw_hs, w_hs, ar_hs;
    logic                 commit;
    logic [AddrWidth-1:0] cm_addr;
    logic [63:0]          cm_data;
    logic [7:0]           cm_strb;
    logic [2:0]           cm_dec;
    logic                 cm_ok;
    logic [2:0]           rd_dec;
    logic [63:0]          rd_val;

    assign aw_ready_o = (wr_state_q == StWIdle) || (wr_state_q == StWHaveW);
    assign w_ready_o  = (wr_state_q == StWIdle) || (wr_state_q == StWHaveAw);
    assign aw_hs      = aw_valid_i && aw_ready_o;
    assign w_hs       = w_valid_i && w_ready_o;
    assign ar_ready_o = (rd_state_q == StRIdle);
    assign ar_hs      = ar_valid_i && ar_ready_o;

    // Write FSM next state; picks live or latched address/data for the commit.
    always_comb begin
        wr_state_d = wr_state_q;
        commit     = 1'b0;
        cm_addr    = aw_addr_i;
        cm_data    = w_data_i;
        cm_strb    = w_strb_i;
        case (wr_state_q)
            StWIdle: begin
                if (aw_hs && w_hs) begin
                    commit     = 1'b1;
                    wr_state_d = StWResp;
                end else if (aw_hs) begin
                    wr_state_d = StWHaveAw;
                end else if (w_hs) begin
                    wr_state_d = StWHaveW;
                end
            end
            StWHaveAw: begin
                cm_addr = wr_addr_q;
                if (w_hs) begin
                    commit     = 1'b1;
                    wr_state_d = StWResp;
                end
            end
            StWHaveW: begin
                cm_data = wr_data_q;
                cm_strb = wr_strb_q;
                if (aw_hs) begin
                    commit     = 1'b1;
                    wr_state_d = StWResp;
                end
            end
            StWResp: begin
                if (b_ready_i) wr_state_d = StWIdle;
            end
            default: wr_state_d = StWIdle;
        endcase
    end

    assign cm_dec = decode(cm_addr);
    assign cm_ok  = cm_dec[2] && (cm_dec[1:0] != IdxCount);

    // Register next state: committed writes plus the saturating counter.
    always_comb begin
        exit_d   = exit_q;
        event_d  = event_q;
        cnt_en_d = cnt_en_q;
        count_d  = count_q;
        if (commit && cm_ok) begin
            case (cm_dec[1:0])
                IdxExit: begin
                    // EXIT is sticky once the done bit is set.
                    if (!exit_q[0]) exit_d = merge(exit_q, cm_data, cm_strb);
                end
                IdxEvent: event_d  = merge(event_q, cm_data, cm_strb);
                IdxCntEn: cnt_en_d = merge(cnt_en_q, cm_data, cm_strb);
                default: ;
            endcase
        end
        // Uses the pre-commit enable, so the commit cycle counts with the old value.
        if (cnt_en_q[0] && (count_q != '1)) count_d = count_q + 64'd1;
    end

    // Write-path state, latched beats, response code and the registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= StWIdle;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            b_resp_q   <= RespOkay;
            exit_q     <= '0;
            event_q    <= '0;
            cnt_en_q   <= '0;
            count_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) wr_addr_q <= aw_addr_i;
            if (w_hs) begin
                wr_data_q <= w_data_i;
                wr_strb_q <= w_strb_i;
            end
            if (commit) b_resp_q <= cm_ok ? RespOkay : RespSlvErr;
            exit_q   <= exit_d;
            event_q  <= event_d;
            cnt_en_q <= cnt_en_d;
            count_q  <= count_d;
        end
    end

    assign rd_dec = decode(ar_addr_i);

    // Read mux over current register values (pre-write on a same-cycle commit).
    always_comb begin
        rd_val = '0;
        case (rd_dec[1:0])
            IdxExit:  rd_val = exit_q;
            IdxEvent: rd_val = event_q;
            IdxCntEn: rd_val = cnt_en_q;
            IdxCount: rd_val = count_q;
            default:  rd_val = '0;
        endcase
    end

    // Read FSM next state.
    always_comb begin
        rd_state_d = rd_state_q;
        if (rd_state_q == StRIdle) begin
            if (ar_hs) rd_state_d = StRResp;
        end else if (r_ready_i) begin
            rd_state_d = StRIdle;
        end
    end

    // Read-path state and registered response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= StRIdle;
            r_data_q   <= '0;
            r_resp_q   <= RespOkay;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_hs) begin
                r_data_q <= rd_dec[2] ? rd_val : 64'd0;
                r_resp_q <= rd_dec[2] ? RespOkay : RespSlvErr;
            end
        end
    end

    assign b_valid_o       = (wr_state_q == StWResp);
    assign b_resp_o        = b_resp_q;
    assign r_valid_o       = (rd_state_q == StRResp);
    assign r_data_o        = r_data_q;
    assign r_resp_o        = r_resp_q;
    assign exit_o          = exit_q;
    assign event_trigger_o = event_q;
    assign hw_cnt_en_o     = cnt_en_q;
    assign cycle_count_o   = count_q;

endmodule
